carry_skip_16bit: RTL and testbench

- 16-bit unsigned adder with carry-in, built as a carry-skip (carry-bypass) structure of four 4-bit ripple blocks.
- The sum and carry-out are registered once on the rising clock edge.
- Used as a datapath arithmetic primitive wherever a registered a+b+cin is needed, with shorter worst-case carry paths than a plain ripple adder.

---
 rtl/carry_skip_16bit.sv | 45 ++++
 tb/tb_carry_skip_16bit.sv | 87 ++++++++
 2 files changed

// File: rtl/carry_skip_16bit.sv
// carry_skip_16bit: registered 16-bit a+b+cin built from four 4-bit ripple blocks with carry-skip muxes
module carry_skip_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [15:0] w_s;
  logic [4:0]  w_bc;
  logic        w_r;
  logic [15:0] r_sum;
  logic        r_cout;
  assign w_p = a ^ b;
  assign w_g = a & b;
  // w_bc[k] is the carry into block k; a fully propagating block forwards it unchanged
  always_comb begin
    w_bc = {4'b0, cin};
    w_s = '0;
    w_r = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_r = w_bc[k];
      for (int i = 0; i < 4; i++) begin
        w_s[4*k+i] = w_p[4*k+i] ^ w_r;
        w_r = w_g[4*k+i] | (w_p[4*k+i] & w_r);
      end
      w_bc[k+1] = (&w_p[4*k +: 4]) ? w_bc[k] : w_r;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_s;
      r_cout <= w_bc[4];
    end
  end
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_carry_skip_16bit.sv
// tb_carry_skip_16bit: scoreboard bench comparing registered {cout,sum} with a+b+cin one edge later
module tb_carry_skip_16bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = 16'h1234;
  logic [15:0] b = 16'h4321;
  logic        cin = 1'b1;
  logic [15:0] sum;
  logic        cout;
  int          errors = 0;
  int          checks = 0;
  logic [16:0] sb_q[$];

  carry_skip_16bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got={cout,sum}=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] exp;
    @(negedge clk);
    a = x;
    b = y;
    cin = c;
    sb_q.push_back({1'b0, x} + {1'b0, y} + {16'b0, c});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) chk({tag, "_empty"}, {cout, sum}, 17'h1ffff);
    else begin
      exp = sb_q.pop_front();
      chk(tag, {cout, sum}, exp);
    end
  endtask

  initial begin
    #2;
    chk("reset_async", {cout, sum}, 17'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", {cout, sum}, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("zero_cin", 16'h0000, 16'h0000, 1'b1);
    step("blk0_ripple", 16'd14, 16'd1, 1'b1);
    step("plain5", 16'd5, 16'd0, 1'b0);
    step("dec999", 16'd999, 16'd0, 1'b1);
    step("full_skip", 16'hFFFF, 16'h0000, 1'b1);
    step("all_ones", 16'hFFFF, 16'hFFFF, 1'b1);
    step("b2b_0", 16'h0F0F, 16'h00F1, 1'b0);
    step("b2b_1", 16'h8000, 16'h8000, 1'b0);
    step("b2b_2", 16'h7FFF, 16'h0001, 1'b0);
    step("skip_mid", 16'h0FF0, 16'h0000, 1'b0);
    step("pre_reset", 16'hABCD, 16'h1111, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_mid", {cout, sum}, 17'h0);
    @(posedge clk);
    #1;
    chk("reset_mid_held", {cout, sum}, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", 16'h00FF, 16'h0001, 1'b0);
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j += 17)
        step("sweep", 16'(i), 16'(j), 1'(i ^ j));
    for (int n = 0; n < 300; n++)
      step("rand", 16'($urandom), 16'($urandom), 1'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
